// File: rtl/rat_ckpt.sv
`default_nettype none
// ============================================================================
// Module   : rat_ckpt
// Brief    : Register alias table (speculative bit + ROB tag per arch reg)
//            with circular branch checkpoints. A mispredict restores the map
//            from its checkpoint in one cycle. Optional feature macro:
//            RAT_CKPT_RETIRE_BYPASS_EN (same-cycle retire clears lookup spec).
// Revision : 1.0 - initial release
// ============================================================================
module rat_ckpt #(
   parameter int N_ARCH_REGS  = 32,
   parameter int ROB_ID_WIDTH = 4,
   parameter int N_SRC_PORTS  = 2,
   parameter int N_CKPTS      = 4,
   localparam int C_AW        = $clog2(N_ARCH_REGS),
   localparam int C_CW        = $clog2(N_CKPTS)
) (
   input  logic                              clk,
   input  logic                              rst_aL,
   input  logic [N_SRC_PORTS*C_AW-1:0]       src_arf_id,
   output logic [N_SRC_PORTS-1:0]            src_spec,
   output logic [N_SRC_PORTS*ROB_ID_WIDTH-1:0] src_rob_id,
   input  logic                              rename_valid,
   input  logic [C_AW-1:0]                   rename_arf_id,
   input  logic [ROB_ID_WIDTH-1:0]           rename_rob_id,
   input  logic                              retire_valid,
   input  logic [C_AW-1:0]                   retire_arf_id,
   input  logic [ROB_ID_WIDTH-1:0]           retire_rob_id,
   input  logic                              ckpt_req_valid,
   output logic                              ckpt_req_ready,
   output logic [C_CW-1:0]                   ckpt_alloc_id,
   input  logic                              ckpt_release_valid,
   input  logic [C_CW-1:0]                   ckpt_release_id,
   input  logic                              recover_valid,
   input  logic [C_CW-1:0]                   recover_id,
   input  logic                              flush_all,
   output logic [C_CW:0]                     ckpt_count
);

   // Live map
   logic [N_ARCH_REGS-1:0]                    r_spec;
   logic [N_ARCH_REGS-1:0][ROB_ID_WIDTH-1:0]  r_tag;
   // Checkpoint slots
   logic [N_CKPTS-1:0]                        r_ck_valid;
   logic [N_CKPTS-1:0][N_ARCH_REGS-1:0]       r_ck_spec;
   logic [N_CKPTS-1:0][N_ARCH_REGS-1:0][ROB_ID_WIDTH-1:0] r_ck_tag;
   logic [C_CW-1:0]                           r_tail;

   // Next-state terms
   logic [N_ARCH_REGS-1:0]                    w_map_spec;
   logic [N_ARCH_REGS-1:0][ROB_ID_WIDTH-1:0]  w_map_tag;
   logic [N_ARCH_REGS-1:0]                    w_rec_spec;
   logic [N_ARCH_REGS-1:0][ROB_ID_WIDTH-1:0]  w_rec_tag;
   logic [N_ARCH_REGS-1:0]                    w_spec_n;
   logic [N_ARCH_REGS-1:0][ROB_ID_WIDTH-1:0]  w_tag_n;
   logic [N_CKPTS-1:0]                        w_ck_valid_n;
   logic [N_CKPTS-1:0][N_ARCH_REGS-1:0]       w_ck_spec_n;
   logic [N_CKPTS-1:0][N_ARCH_REGS-1:0][ROB_ID_WIDTH-1:0] w_ck_tag_n;
   logic [C_CW-1:0]                           w_tail_n;
   logic [C_CW-1:0]                           w_rec_span;
   logic [C_CW-1:0]                           w_dist;
   logic                                      w_alloc;
   logic [C_CW:0]                             w_count;

   // Lookup ports read registered state only (plus optional retire bypass)
   for (genvar p = 0; p < N_SRC_PORTS; p++) begin : g_src
      logic [C_AW-1:0] w_addr;
      logic            w_bypass;
      assign w_addr = src_arf_id[p*C_AW +: C_AW];
`ifdef RAT_CKPT_RETIRE_BYPASS_EN
      assign w_bypass = retire_valid && (retire_arf_id == w_addr) &&
                        (retire_rob_id == r_tag[w_addr]);
`else
      assign w_bypass = 1'b0;
`endif
      assign src_spec[p] = (w_addr != '0) && r_spec[w_addr] && !w_bypass;
      assign src_rob_id[p*ROB_ID_WIDTH +: ROB_ID_WIDTH] =
         (w_addr == '0) ? '0 : r_tag[w_addr];
   end

   // A slot is only handed out once the tail has reached a released slot
   assign ckpt_req_ready = ~r_ck_valid[r_tail] & ~recover_valid & ~flush_all;
   assign ckpt_alloc_id  = r_tail;
   assign w_alloc        = ckpt_req_valid & ckpt_req_ready;
   assign ckpt_count     = w_count;

   // Candidate maps: normal path (retire then rename, so rename wins) and
   // recovery path (checkpoint contents with this cycle's retire on top)
   always_comb begin
      w_map_spec = r_spec;
      w_map_tag  = r_tag;
      if (retire_valid && r_spec[retire_arf_id] &&
          (r_tag[retire_arf_id] == retire_rob_id))
         w_map_spec[retire_arf_id] = 1'b0;
      if (rename_valid && (rename_arf_id != '0)) begin
         w_map_spec[rename_arf_id] = 1'b1;
         w_map_tag[rename_arf_id]  = rename_rob_id;
      end
      w_rec_spec = r_ck_spec[recover_id];
      w_rec_tag  = r_ck_tag[recover_id];
      if (retire_valid && w_rec_spec[retire_arf_id] &&
          (w_rec_tag[retire_arf_id] == retire_rob_id))
         w_rec_spec[retire_arf_id] = 1'b0;
   end

   // Select the live map: flush > recover > normal; tags stay stale on flush
   always_comb begin
      w_spec_n = w_map_spec;
      w_tag_n  = w_map_tag;
      if (flush_all) begin
         w_spec_n = '0;
         w_tag_n  = r_tag;
      end else if (recover_valid) begin
         w_spec_n = w_rec_spec;
         w_tag_n  = w_rec_tag;
      end
   end

   // Checkpoint slot bookkeeping: retire scrubbing, alloc, release, squash
   always_comb begin
      w_ck_valid_n = r_ck_valid;
      w_ck_spec_n  = r_ck_spec;
      w_ck_tag_n   = r_ck_tag;
      w_tail_n     = r_tail;
      w_rec_span   = r_tail - recover_id;
      w_dist       = '0;
      for (int k = 0; k < N_CKPTS; k++) begin
         if (retire_valid && r_ck_valid[k] && r_ck_spec[k][retire_arf_id] &&
             (r_ck_tag[k][retire_arf_id] == retire_rob_id))
            w_ck_spec_n[k][retire_arf_id] = 1'b0;
      end
      if (flush_all) begin
         w_ck_valid_n = '0;
         w_tail_n     = '0;
      end else if (recover_valid) begin
         // Squash recover_id..tail-1; a zero span means the ring is full
         for (int k = 0; k < N_CKPTS; k++) begin
            w_dist = C_CW'(k) - recover_id;
            if ((w_rec_span == '0) || (w_dist < w_rec_span))
               w_ck_valid_n[k] = 1'b0;
         end
         w_tail_n = recover_id + 1'b1;
      end else begin
         if (ckpt_release_valid)
            w_ck_valid_n[ckpt_release_id] = 1'b0;
         if (w_alloc) begin
            w_ck_valid_n[r_tail] = 1'b1;
            w_ck_spec_n[r_tail]  = w_map_spec;
            w_ck_tag_n[r_tail]   = w_map_tag;
            w_tail_n             = r_tail + 1'b1;
         end
      end
   end

   // Live checkpoint population count
   always_comb begin
      w_count = '0;
      for (int k = 0; k < N_CKPTS; k++)
         w_count = w_count + (C_CW+1)'(r_ck_valid[k]);
   end

   // State registers; reset discards every checkpoint immediately
   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         r_spec     <= '0;
         r_tag      <= '0;
         r_ck_valid <= '0;
         r_ck_spec  <= '0;
         r_ck_tag   <= '0;
         r_tail     <= '0;
      end else begin
         r_spec     <= w_spec_n;
         r_tag      <= w_tag_n;
         r_ck_valid <= w_ck_valid_n;
         r_ck_spec  <= w_ck_spec_n;
         r_ck_tag   <= w_ck_tag_n;
         r_tail     <= w_tail_n;
      end
   end

   // A mispredict must name a live checkpoint
   a_recover_live : assert property (@(posedge clk) disable iff (!rst_aL)
      (recover_valid && !flush_all) |-> r_ck_valid[recover_id]);

endmodule
`default_nettype wire

// File: tb/tb_rat_ckpt.sv
`default_nettype none
// ============================================================================
// Module   : tb_rat_ckpt
// Brief    : Scoreboard bench for rat_ckpt: directed scenarios plus random
//            traffic against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rat_ckpt;
   localparam int NR = 32, RW = 4, NS = 2, NC = 4, AW = 5, CW = 2;

   logic clk = 1'b0;
   logic rst_aL = 1'b0;
   logic [NS*AW-1:0] src_arf_id;
   logic [NS-1:0]    src_spec;
   logic [NS*RW-1:0] src_rob_id;
   logic             rename_valid, retire_valid, ckpt_req_valid, ckpt_req_ready;
   logic [AW-1:0]    rename_arf_id, retire_arf_id;
   logic [RW-1:0]    rename_rob_id, retire_rob_id;
   logic [CW-1:0]    ckpt_alloc_id, ckpt_release_id, recover_id;
   logic             ckpt_release_valid, recover_valid, flush_all;
   logic [CW:0]      ckpt_count;

   always #5 clk = ~clk;

   rat_ckpt #(.N_ARCH_REGS(NR), .ROB_ID_WIDTH(RW), .N_SRC_PORTS(NS), .N_CKPTS(NC)) dut (
      .clk(clk), .rst_aL(rst_aL), .src_arf_id(src_arf_id), .src_spec(src_spec),
      .src_rob_id(src_rob_id), .rename_valid(rename_valid), .rename_arf_id(rename_arf_id),
      .rename_rob_id(rename_rob_id), .retire_valid(retire_valid),
      .retire_arf_id(retire_arf_id), .retire_rob_id(retire_rob_id),
      .ckpt_req_valid(ckpt_req_valid), .ckpt_req_ready(ckpt_req_ready),
      .ckpt_alloc_id(ckpt_alloc_id), .ckpt_release_valid(ckpt_release_valid),
      .ckpt_release_id(ckpt_release_id), .recover_valid(recover_valid),
      .recover_id(recover_id), .flush_all(flush_all), .ckpt_count(ckpt_count));

   // Reference model: architectural map plus a ring of checkpoint snapshots
   bit            m_spec[NR];
   logic [RW-1:0] m_tag[NR];
   bit            m_live[NC];
   bit            m_cs[NC][NR];
   logic [RW-1:0] m_ct[NC][NR];
   int            m_tail;

   typedef struct packed {
      logic [NS-1:0]    sp;
      logic [NS*RW-1:0] tg;
      logic             rdy;
      logic [CW-1:0]    aid;
      logic [CW:0]      cnt;
   } exp_t;
   exp_t q[$];
   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: outputs are sampled mid-cycle against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("src_spec",   32'(src_spec),       32'(e.sp));
            check("src_rob_id", 32'(src_rob_id),     32'(e.tg));
            check("ready",      32'(ckpt_req_ready), 32'(e.rdy));
            check("alloc_id",   32'(ckpt_alloc_id),  32'(e.aid));
            check("count",      32'(ckpt_count),     32'(e.cnt));
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin m_spec[i] = 0; m_tag[i] = '0; end
      for (int k = 0; k < NC; k++) begin
         m_live[k] = 0;
         for (int i = 0; i < NR; i++) begin m_cs[k][i] = 0; m_ct[k][i] = '0; end
      end
      m_tail = 0;
   endtask

   task automatic push_expect();
      exp_t e;
      int   a, live;
      bit   sp;
      live = 0;
      for (int p = 0; p < NS; p++) begin
         a  = int'(src_arf_id[p*AW +: AW]);
         sp = (a != 0) && m_spec[a];
`ifdef RAT_CKPT_RETIRE_BYPASS_EN
         if (retire_valid && int'(retire_arf_id) == a && retire_rob_id == m_tag[a]) sp = 0;
`endif
         e.sp[p] = sp;
         e.tg[p*RW +: RW] = (a == 0) ? '0 : m_tag[a];
      end
      e.rdy = !m_live[m_tail] && !recover_valid && !flush_all;
      e.aid = CW'(m_tail);
      for (int k = 0; k < NC; k++) live += int'(m_live[k]);
      e.cnt = (CW+1)'(live);
      q.push_back(e);
   endtask

   task automatic model_update();
      int ra, r, n;
      bit fire;
      ra   = int'(retire_arf_id);
      fire = ckpt_req_valid && !m_live[m_tail] && !recover_valid && !flush_all;
      // Retiring a tag frees it in every live snapshot too
      if (retire_valid)
         for (int k = 0; k < NC; k++)
            if (m_live[k] && m_cs[k][ra] && m_ct[k][ra] == retire_rob_id) m_cs[k][ra] = 0;
      if (flush_all) begin
         for (int i = 0; i < NR; i++) m_spec[i] = 0;
         for (int k = 0; k < NC; k++) m_live[k] = 0;
         m_tail = 0;
      end else if (recover_valid) begin
         r = int'(recover_id);
         for (int i = 0; i < NR; i++) begin m_spec[i] = m_cs[r][i]; m_tag[i] = m_ct[r][i]; end
         n = (m_tail - r + NC) % NC;
         if (n == 0) n = NC;
         for (int i = 0; i < n; i++) m_live[(r + i) % NC] = 0;
         m_tail = (r + 1) % NC;
      end else begin
         if (retire_valid && m_spec[ra] && m_tag[ra] == retire_rob_id) m_spec[ra] = 0;
         if (rename_valid && rename_arf_id != 0) begin
            m_spec[rename_arf_id] = 1;
            m_tag[rename_arf_id]  = rename_rob_id;
         end
         if (ckpt_release_valid) m_live[ckpt_release_id] = 0;
         if (fire) begin
            m_live[m_tail] = 1;
            for (int i = 0; i < NR; i++) begin m_cs[m_tail][i] = m_spec[i]; m_ct[m_tail][i] = m_tag[i]; end
            m_tail = (m_tail + 1) % NC;
         end
      end
   endtask

   task automatic idle_in();
      rename_valid = 0; rename_arf_id = '0; rename_rob_id = '0;
      retire_valid = 0; retire_arf_id = '0; retire_rob_id = '0;
      ckpt_req_valid = 0; ckpt_release_valid = 0; ckpt_release_id = '0;
      recover_valid = 0; recover_id = '0; flush_all = 0;
   endtask

   task automatic lk(input int a0, input int a1);
      src_arf_id = {AW'(a1), AW'(a0)};
   endtask
   task automatic ren(input int a, input int r);
      rename_valid = 1; rename_arf_id = AW'(a); rename_rob_id = RW'(r);
   endtask
   task automatic ret(input int a, input int r);
      retire_valid = 1; retire_arf_id = AW'(a); retire_rob_id = RW'(r);
   endtask
   task automatic ck();                 ckpt_req_valid = 1; endtask
   task automatic rel(input int id);    ckpt_release_valid = 1; ckpt_release_id = CW'(id); endtask
   task automatic rec(input int id);    recover_valid = 1; recover_id = CW'(id); endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle_in();
   endtask
   task automatic go();
      push_expect();
      model_update();
   endtask

   // Asynchronous reset pulse placed between clock edges
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_aL = 1'b0;
      idle_in();
      model_reset();
      #1;
      rst_aL = 1'b1;
      go();
   endtask

   task automatic rand_step();
      int r;
      tick();
      lk(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7)),
         int'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 1) ren(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) begin
         r = int'($urandom_range(0, 7));
         ret(r, ($urandom_range(0, 2) != 0) ? int'(m_tag[r]) : int'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 2) != 0) ck();
      if ($urandom_range(0, 2) == 0) rel(int'($urandom_range(0, NC - 1)));
      if ($urandom_range(0, 7) == 0) begin
         r = int'($urandom_range(0, NC - 1));
         if (m_live[r]) rec(r);
      end
      if ($urandom_range(0, 49) == 0) flush_all = 1;
      go();
   endtask

   initial begin
      idle_in();
      lk(5, 0);
      model_reset();
      repeat (2) @(posedge clk);
      // Reset state
      do_reset();

      // Checkpoint then mispredict restores the older mapping
      tick(); lk(5, 0); ren(5, 7); go();
      tick(); lk(5, 0); ck(); go();
      tick(); lk(5, 0); ren(5, 9); go();
      tick(); lk(5, 0); rec(0); go();
      tick(); lk(5, 0); go();
      // Retire clears the checkpoint copy as well
      tick(); lk(3, 5); ren(3, 4); go();
      tick(); lk(3, 5); ck(); go();
      tick(); lk(3, 5); ret(3, 4); go();
      tick(); lk(3, 5); rec(1); go();
      tick(); lk(3, 5); go();

      // Full ring, out-of-order release
      do_reset();
      repeat (4) begin tick(); ck(); go(); end
      tick(); go();
      tick(); rel(2); go();
      tick(); go();
      tick(); rel(0); go();
      tick(); go();

      // Rename beats retire; recover drops a same-cycle rename
      do_reset();
      tick(); lk(8, 9); ren(8, 2); go();
      tick(); lk(8, 9); ren(8, 2); ret(8, 2); go();
      tick(); lk(8, 9); go();
      tick(); lk(8, 9); ck(); go();
      tick(); lk(8, 9); rec(0); ren(9, 5); go();
      tick(); lk(8, 9); go();

      // Flush with live checkpoints; x0 is never renamed
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         tick(); lk(i, 0); ren(i, i + 8); if (i <= 3) ck(); go();
      end
      tick(); lk(1, 5); go();
      tick(); lk(1, 5); flush_all = 1; go();
      tick(); lk(1, 5); go();
      tick(); lk(0, 3); ren(0, 6); go();
      tick(); lk(0, 3); go();

      // Random traffic with a mid-run asynchronous reset
      for (int c = 0; c < 1500; c++) begin
         rand_step();
         if (c == 700) do_reset();
      end
      tick(); go();
      repeat (3) @(posedge clk);
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rat_ckpt.md
# rat_ckpt

Parametrised register alias table (ARF/ROB speculative bit plus ROB-tag map) with branch checkpoints, succeeding the flush-only rename tables in dispatch. Branches snapshot the map at dispatch. A mispredict restores the map in one cycle from its checkpoint and keeps older speculative mappings, instead of marking every register retired. The block sits in the dispatch stage, between decode and the ROB/issue-queue interfaces.

## Interface

Parameters:
- `N_ARCH_REGS`, 32: architectural registers; entry 0 is hardwired x0.
- `ROB_ID_WIDTH`, 4: ROB tag width.
- `N_SRC_PORTS`, 2: combinational lookup ports.
- `N_CKPTS`, 4: checkpoint slots; power of 2, ≥2.

Ports (`AW` = `$clog2(N_ARCH_REGS)`, `CW` = `$clog2(N_CKPTS)`):
- `clk` in 1: single clock, rising edge.
- `rst_aL` in 1: asynchronous, active-low reset.
- `src_arf_id` in `N_SRC_PORTS*AW`: lookup addresses.
- `src_spec` out `N_SRC_PORTS`: 1 = operand comes from the ROB, 0 = operand comes from the ARF.
- `src_rob_id` out `N_SRC_PORTS*ROB_ID_WIDTH`: current tag for each lookup.
- `rename_valid` in 1, `rename_arf_id` in `AW`, `rename_rob_id` in `ROB_ID_WIDTH`: map rd to a new tag.
- `retire_valid` in 1, `retire_arf_id` in `AW`, `retire_rob_id` in `ROB_ID_WIDTH`: ROB head retiring with a destination.
- `ckpt_req_valid` in 1, `ckpt_req_ready` out 1, `ckpt_alloc_id` out `CW`: checkpoint allocation handshake.
- `ckpt_release_valid` in 1, `ckpt_release_id` in `CW`: branch resolved correctly.
- `recover_valid` in 1, `recover_id` in `CW`: mispredicted branch.
- `flush_all` in 1: full redirect at retire.
- `ckpt_count` out `CW+1`: number of live checkpoints.

## Operation

- State: `spec[N_ARCH_REGS]`, `tag[N_ARCH_REGS]`, per-slot `ck_valid`, `ck_spec`, `ck_tag`, and tail pointer `tail` (`CW` bits).
- Lookup is combinational from registered state. It does not see a rename in the same cycle. Address 0 always returns spec=0, tag=0.
- Rename (when `rename_valid` and `arf_id != 0`): set `spec`=1 and `tag`=`rename_rob_id`. A rename of address 0 is ignored.
- Retire: if `spec[id]` and `tag[id] == retire_rob_id`, clear `spec[id]`.
  - The same compare and clear is applied to every valid checkpoint slot.
  - This ensures a restore never points at a freed ROB entry.
- Checkpoint allocation:
  - `ckpt_req_ready = ~ck_valid[tail] & ~recover_valid & ~flush_all`.
  - `ckpt_alloc_id = tail`.
  - On fire, the slot captures the map including the same-cycle rename and retire. The slot's `ck_valid` is set and `tail` increments (mod `N_CKPTS`).
- Release: clear `ck_valid[ckpt_release_id]`. The slot is reusable only when `tail` reaches it. Out-of-order release is allowed.
- Recover:
  - Load `spec`/`tag` from slot `recover_id`, with the same-cycle retire applied on top.
  - Clear `ck_valid` for `recover_id` and every slot after it, up to `tail-1` (circular).
  - Set `tail = recover_id + 1`.
- `flush_all`: clear all `spec` bits and all `ck_valid`; set `tail`=0. Tags are left stale.
- Priority: `flush_all` > `recover_valid` > rename/alloc/release.
  - During a recover or flush, rename, allocation and release are dropped.
  - Retire still applies to the resulting map.
- Same cycle, same arf_id: rename beats retire.
- `ckpt_count` is the popcount of `ck_valid`.

## Timing

- Reset: `spec`=0, `tag`=0, `ck_valid`=0, `tail`=0.
  - Outputs after reset: `src_spec`=0, `src_rob_id`=0, `ckpt_req_ready`=1, `ckpt_alloc_id`=0, `ckpt_count`=0.
- Reset mid-operation discards all checkpoints immediately (asynchronous).
- Lookup: 0-cycle latency. Rename, retire, alloc, release and recover: visible on lookup the next cycle.
- Full: when all `N_CKPTS` slots are live, `ckpt_req_ready`=0. Dispatch stalls the branch; there is no overwrite.
- Wrap: `tail` wraps from `N_CKPTS-1` to 0.
- Recover of a slot whose `ck_valid`=0 is illegal. An assertion flags it in simulation.

## Configuration

- `RAT_CKPT_RETIRE_BYPASS_EN` defined:
  - A lookup whose address and tag match a same-cycle valid retire returns `src_spec`=0.
  - Dispatch then reads the ARF value being written this cycle through the ARF write-through.
- Undefined: lookup reflects registered state only. `src_spec`=1 in that cycle, and the operand is taken from the ROB.

## Test plan

- Reset, then look up x5: `src_spec`=0, tag 0, `ckpt_req_ready`=1, `ckpt_count`=0.
- Rename x5→7; next cycle checkpoint (id 0); rename x5→9; recover id 0: x5 reads spec=1, tag 7, `tail`=1, `ckpt_count`=0.
- Allocate 4 checkpoints: `ckpt_req_ready`=0 and `ckpt_count`=4. Release id 2: still not ready. Release id 0: ready, `ckpt_alloc_id`=0.
- Rename x3→4; checkpoint id 1; retire x3 tag 4; recover id 1: x3 spec=0, because the checkpoint was also cleared.
- Same cycle: rename x8→2 and retire x8 tag 2 (prior tag 2): x8 spec=1, tag 2. Same cycle: recover and rename x9: rename dropped.
- `flush_all` with 3 live checkpoints and 5 speculative registers: all spec=0, `ckpt_count`=0, `tail`=0. Rename x0→6: x0 still spec=0.
